// File: rtl/stream_pkg.sv
// Shared types and default sizing for the UART-to-EEPROM page assembly path.
package stream_pkg;

  localparam int DEF_PAGE_BYTES = 128;
  localparam int DEF_NUM_PAGES  = 1024;

  typedef enum logic [1:0] {IDLE, FILL, PAD} fill_state_t;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, OWNED} buf_state_t;

endpackage

// File: rtl/page_ram.sv
// Two page buffers in one simple dual-port RAM: sync write, registered read.
module page_ram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/page_assembler.sv
// Drains the UART FIFO into ping-pong page buffers and hands full pages to the
// EEPROM writer. Optional per-page XOR checksum under macro PAGE_CSUM_EN.
//
// state | meaning
// IDLE  | waiting for an EMPTY fill buffer and FIFO data
// FILL  | reading FIFO bytes into the fill buffer
// PAD   | idle timeout hit; writing PAD_BYTE to finish the page
module page_assembler
  import stream_pkg::*;
#(
  parameter int         PAGE_BYTES  = DEF_PAGE_BYTES,
  parameter int         NUM_PAGES   = DEF_NUM_PAGES,
  parameter int         TIMEOUT_CYC = 70000,
  parameter logic [7:0] PAD_BYTE    = 8'hFF
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          fifo_empty,
  input  logic [7:0]                    fifo_dout,
  output logic                          fifo_rd_en,
  output logic                          page_valid,
  input  logic                          page_take,
  output logic [9:0]                    page_num,
  input  logic [$clog2(PAGE_BYTES)-1:0] rd_idx,
  output logic [7:0]                    rd_data,
  input  logic                          page_release,
  output logic                          image_done,
  output logic [7:0]                    page_csum
);

  localparam int IDX_W = $clog2(PAGE_BYTES);
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PAGE_BYTES - 1);
  localparam logic [IDX_W:0]   PAGE_CNT  = (IDX_W+1)'(PAGE_BYTES);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [9:0]       LAST_PAGE = 10'(NUM_PAGES - 1);

  fill_state_t      fill_st, fill_nxt;
  buf_state_t       buf_st [2];
  logic             fill_ptr, rd_ptr, rd_en_q;
  logic [IDX_W-1:0] count, count_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [9:0]       page_cnt;
  logic             start_fill, complete, wr_en, take, rel;
  logic [7:0]       wr_data;
  logic [IDX_W:0]   pending;

  // Bytes committed to this page, counting a read whose data lands next cycle.
  assign pending    = {1'b0, count} + {{IDX_W{1'b0}}, rd_en_q};
  assign page_valid = (buf_st[rd_ptr] == FULL);
  assign take       = page_valid & page_take;
  assign rel        = (buf_st[rd_ptr] == OWNED) & page_release;
  assign page_num   = page_cnt;

  always_comb begin
    fill_nxt   = fill_st;
    fifo_rd_en = 1'b0;
    start_fill = 1'b0;
    wr_en      = 1'b0;
    wr_data    = fifo_dout;
    complete   = 1'b0;
    count_nxt  = count;
    timer_nxt  = timer;
    case (fill_st)
      IDLE: begin
        if (buf_st[fill_ptr] == EMPTY && !fifo_empty) begin
          fill_nxt   = FILL;
          start_fill = 1'b1;
        end
      end
      FILL: begin
        fifo_rd_en = !fifo_empty && (pending < PAGE_CNT);
        wr_en      = rd_en_q;
        if (fifo_rd_en)          timer_nxt = '0;
        else if (count != '0)    timer_nxt = timer + 1'b1;
        if (wr_en && count == LAST_IDX) begin
          complete = 1'b1;
        end else if (!fifo_rd_en && !rd_en_q && count != '0 && timer == TMR_LAST) begin
          fill_nxt  = PAD;
          timer_nxt = '0;
        end
      end
      PAD: begin
        wr_en   = 1'b1;
        wr_data = PAD_BYTE;
        if (count == LAST_IDX) complete = 1'b1;
      end
      default: fill_nxt = IDLE;
    endcase
    if (wr_en) count_nxt = count + 1'b1;
    if (complete) begin
      fill_nxt  = IDLE;
      count_nxt = '0;
      timer_nxt = '0;
    end
  end

  // Fill completion and take/release always touch different buffers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fill_st    <= IDLE;
      count      <= '0;
      timer      <= '0;
      rd_en_q    <= 1'b0;
      fill_ptr   <= 1'b0;
      rd_ptr     <= 1'b0;
      page_cnt   <= '0;
      image_done <= 1'b0;
      buf_st[0]  <= EMPTY;
      buf_st[1]  <= EMPTY;
    end else begin
      fill_st    <= fill_nxt;
      count      <= count_nxt;
      timer      <= timer_nxt;
      rd_en_q    <= fifo_rd_en;
      image_done <= rel && (page_cnt == LAST_PAGE);
      if (start_fill) buf_st[fill_ptr] <= FILLING;
      if (complete) begin
        buf_st[fill_ptr] <= FULL;
        fill_ptr         <= ~fill_ptr;
      end
      if (take) buf_st[rd_ptr] <= OWNED;
      if (rel) begin
        buf_st[rd_ptr] <= EMPTY;
        rd_ptr         <= ~rd_ptr;
        page_cnt       <= (page_cnt == LAST_PAGE) ? '0 : page_cnt + 1'b1;
      end
    end
  end

  page_ram #(.AW(IDX_W + 1)) u_ram (
    .clk     (clk),
    .nrst    (nrst),
    .wr_en   (wr_en),
    .wr_addr ({fill_ptr, count}),
    .wr_data (wr_data),
    .rd_addr ({rd_ptr, rd_idx}),
    .rd_data (rd_data)
  );

`ifdef PAGE_CSUM_EN
  logic [7:0] csum [2];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      csum[0] <= '0;
      csum[1] <= '0;
    end else if (start_fill) begin
      csum[fill_ptr] <= '0;
    end else if (wr_en) begin
      csum[fill_ptr] <= csum[fill_ptr] ^ wr_data;
    end
  end

  assign page_csum = (buf_st[rd_ptr] == FULL || buf_st[rd_ptr] == OWNED) ? csum[rd_ptr] : 8'h00;
`else
  assign page_csum = 8'h00;
`endif

endmodule

// File: tb/tb_page_assembler.sv
// Randomized self-checking bench for page_assembler against a byte-stream page model.
module tb_page_assembler;

  localparam int         PB   = 128;
  localparam int         NP   = 8;
  localparam int         TO   = 300;
  localparam logic [7:0] PADB = 8'hFF;

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic       fifo_empty;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_rd_en;
  logic       page_valid;
  logic       page_take = 1'b0;
  logic [9:0] page_num;
  logic [6:0] rd_idx = 7'd0;
  logic [7:0] rd_data;
  logic       page_release = 1'b0;
  logic       image_done;
  logic [7:0] page_csum;

  int checks = 0;
  int errors = 0;

  logic [7:0] fmem [0:8191];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         rd_pulses = 0;

  logic [7:0] exp_stream [$];
  int         fill_pos = 0;
  int         exp_pn = 0;
  logic [7:0] got [PB];
  logic [7:0] exp_pg [PB];

  page_assembler #(.NUM_PAGES(NP), .TIMEOUT_CYC(TO), .PAD_BYTE(PADB)) dut (
    .clk(clk), .nrst(nrst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .page_valid(page_valid), .page_take(page_take),
    .page_num(page_num), .rd_idx(rd_idx), .rd_data(rd_data),
    .page_release(page_release), .image_done(image_done), .page_csum(page_csum)
  );

  always #5 clk = ~clk;

  // FIFO model: data valid the cycle after the read strobe, flushed by reset.
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (!nrst) rd_ptr <= wr_ptr;
    else if (fifo_rd_en) begin
      rd_pulses <= rd_pulses + 1;
      if (rd_ptr != wr_ptr) begin
        fifo_dout <= fmem[rd_ptr % 8192];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  task automatic cycle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [7:0] b);
    fmem[wr_ptr % 8192] = b;
    wr_ptr = wr_ptr + 1;
    exp_stream.push_back(b);
    fill_pos = (fill_pos + 1) % PB;
  endtask

  // A partial page is completed with pad bytes after the idle timeout.
  task automatic model_pad();
    while (fill_pos != 0) begin
      exp_stream.push_back(PADB);
      fill_pos = (fill_pos + 1) % PB;
    end
  endtask

  function automatic logic [7:0] next_page();
    logic [7:0] x = 8'h00;
    for (int i = 0; i < PB; i++) begin
      exp_pg[i] = (exp_stream.size() > 0) ? exp_stream.pop_front() : 8'h00;
      x = x ^ exp_pg[i];
    end
`ifdef PAGE_CSUM_EN
    return x;
`else
    return 8'h00;
`endif
  endfunction

  task automatic grab_page(input int budget, output bit ok, output logic [9:0] pn,
                           output logic [7:0] cs, output logic va_after);
    int c = 0;
    ok = 1'b0; pn = '0; cs = '0; va_after = 1'b1;
    while (!page_valid && c < budget) begin cycle(1); c++; end
    if (!page_valid) return;
    ok = 1'b1; pn = page_num; cs = page_csum;
    page_take = 1'b1; cycle(1); page_take = 1'b0;
    va_after = page_valid;
    for (int i = 0; i < PB; i++) begin
      rd_idx = 7'(i);
      cycle(1);
      got[i] = rd_data;
    end
  endtask

  task automatic release_page(output logic d1, output logic d2);
    page_release = 1'b1; cycle(1); page_release = 1'b0;
    d1 = image_done;
    cycle(1);
    d2 = image_done;
  endtask

  task automatic test_reset();
    #1 nrst = 1'b0;
    cycle(3);
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", fifo_rd_en); end
    checks++; if (page_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", page_valid); end
    checks++; if (page_num !== 10'd0) begin errors++; $display("FAIL reset_page_num got %0d exp 0", page_num); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp 00", rd_data); end
    checks++; if (image_done !== 1'b0) begin errors++; $display("FAIL reset_image_done got %b exp 0", image_done); end
    checks++; if (page_csum !== 8'h00) begin errors++; $display("FAIL reset_csum got %h exp 00", page_csum); end
    nrst = 1'b1;
    cycle(2);
    checks++; if (page_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got valid %b rd_en %b exp 0 0", page_valid, fifo_rd_en); end
  endtask

  task automatic test_basic();
    bit ok; logic [9:0] pn; logic [7:0] cs, ecs; logic va, d1, d2;
    for (int i = 0; i < PB; i++) push(8'(i));
    grab_page(400, ok, pn, cs, va);
    ecs = next_page();
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got no page_valid exp page"); end
    checks++; if (pn !== 10'(exp_pn)) begin errors++; $display("FAIL basic_page_num got %0d exp %0d", pn, exp_pn); end
    checks++; if (cs !== ecs) begin errors++; $display("FAIL basic_csum got %h exp %h", cs, ecs); end
    checks++; if (va !== 1'b0) begin errors++; $display("FAIL basic_valid_after_take got %b exp 0", va); end
    for (int i = 0; i < PB; i++) begin
      checks++; if (got[i] !== exp_pg[i]) begin errors++; $display("FAIL basic_data idx %0d got %h exp %h", i, got[i], exp_pg[i]); end
    end
    release_page(d1, d2);
    checks++; if (d1 !== 1'b0) begin errors++; $display("FAIL basic_image_done got %b exp 0", d1); end
    exp_pn = (exp_pn + 1) % NP;
  endtask

  task automatic test_backpressure();
    bit ok; logic [9:0] pn; logic [7:0] cs, ecs; logic va, d1, d2;
    int base = rd_pulses;
    for (int i = 0; i < 300; i++) push(8'($urandom));
    cycle(450);
    checks++; if (rd_pulses - base != 256) begin errors++; $display("FAIL bp_reads got %0d exp 256", rd_pulses - base); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL bp_rd_en_held got %b exp 0", fifo_rd_en); end
    checks++; if (page_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", page_valid); end
    model_pad();
    for (int p = 0; p < 3; p++) begin
      grab_page(1000, ok, pn, cs, va);
      ecs = next_page();
      checks++; if (!ok) begin errors++; $display("FAIL bp_timeout page %0d got no page_valid exp page", p); end
      checks++; if (pn !== 10'(exp_pn)) begin errors++; $display("FAIL bp_page_num got %0d exp %0d", pn, exp_pn); end
      checks++; if (cs !== ecs) begin errors++; $display("FAIL bp_csum got %h exp %h", cs, ecs); end
      for (int i = 0; i < PB; i++) begin
        checks++; if (got[i] !== exp_pg[i]) begin errors++; $display("FAIL bp_data page %0d idx %0d got %h exp %h", p, i, got[i], exp_pg[i]); end
      end
      release_page(d1, d2);
      exp_pn = (exp_pn + 1) % NP;
    end
    checks++; if (rd_pulses - base != 300) begin errors++; $display("FAIL bp_total_reads got %0d exp 300", rd_pulses - base); end
  endtask

  task automatic test_pad();
    bit ok; logic [9:0] pn; logic [7:0] cs, ecs; logic va, d1, d2;
    for (int i = 0; i < 5; i++) push(8'h11);
    cycle(TO - 40);
    checks++; if (page_valid !== 1'b0) begin errors++; $display("FAIL pad_early_valid got %b exp 0", page_valid); end
    model_pad();
    grab_page(1000, ok, pn, cs, va);
    ecs = next_page();
    checks++; if (!ok) begin errors++; $display("FAIL pad_timeout got no page_valid exp page"); end
    checks++; if (pn !== 10'(exp_pn)) begin errors++; $display("FAIL pad_page_num got %0d exp %0d", pn, exp_pn); end
    checks++; if (cs !== ecs) begin errors++; $display("FAIL pad_csum got %h exp %h", cs, ecs); end
    for (int i = 0; i < PB; i++) begin
      checks++; if (got[i] !== exp_pg[i]) begin errors++; $display("FAIL pad_data idx %0d got %h exp %h", i, got[i], exp_pg[i]); end
    end
    release_page(d1, d2);
    exp_pn = (exp_pn + 1) % NP;
  endtask

  task automatic test_wrap();
    bit ok; logic [9:0] pn; logic [7:0] cs, ecs; logic va, d1, d2;
    int n = NP - exp_pn + 1;
    int pulses = 0;
    for (int i = 0; i < n * PB; i++) push(8'($urandom));
    for (int k = 0; k < n; k++) begin
      grab_page(600, ok, pn, cs, va);
      ecs = next_page();
      checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout got no page_valid exp page %0d", exp_pn); end
      checks++; if (pn !== 10'(exp_pn)) begin errors++; $display("FAIL wrap_page_num got %0d exp %0d", pn, exp_pn); end
      checks++; if (cs !== ecs) begin errors++; $display("FAIL wrap_csum got %h exp %h", cs, ecs); end
      for (int i = 0; i < PB; i++) begin
        checks++; if (got[i] !== exp_pg[i]) begin errors++; $display("FAIL wrap_data page %0d idx %0d got %h exp %h", exp_pn, i, got[i], exp_pg[i]); end
      end
      release_page(d1, d2);
      checks++; if (d1 !== (exp_pn == NP - 1)) begin errors++; $display("FAIL wrap_image_done page %0d got %b exp %b", exp_pn, d1, exp_pn == NP - 1); end
      checks++; if (d2 !== 1'b0) begin errors++; $display("FAIL wrap_image_done_width got %b exp 0", d2); end
      if (d1 === 1'b1) pulses++;
      exp_pn = (exp_pn + 1) % NP;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL wrap_done_count got %0d exp 1", pulses); end
  endtask

  task automatic test_simultaneous();
    bit ok; logic [9:0] pn; logic [7:0] cs, ecs; logic va, d1, d2;
    int base, c;
    for (int i = 0; i < PB; i++) push(8'($urandom));
    grab_page(400, ok, pn, cs, va);
    ecs = next_page();
    checks++; if (!ok || pn !== 10'(exp_pn)) begin errors++; $display("FAIL sim_first_page got ok %b num %0d exp 1 %0d", ok, pn, exp_pn); end
    for (int i = 0; i < PB; i++) begin
      checks++; if (got[i] !== exp_pg[i]) begin errors++; $display("FAIL sim_first_data idx %0d got %h exp %h", i, got[i], exp_pg[i]); end
    end
    base = rd_pulses;
    for (int i = 0; i < 2 * PB; i++) push(8'($urandom));
    c = 0;
    while (rd_pulses - base < PB && c < 600) begin cycle(1); c++; end
    checks++; if (rd_pulses - base != PB) begin errors++; $display("FAIL sim_align_reads got %0d exp %0d", rd_pulses - base, PB); end
    // The last read's data is written on the next edge, together with this release.
    page_release = 1'b1; cycle(1); page_release = 1'b0;
    exp_pn = (exp_pn + 1) % NP;
    for (int p = 0; p < 2; p++) begin
      grab_page(800, ok, pn, cs, va);
      ecs = next_page();
      checks++; if (!ok) begin errors++; $display("FAIL sim_timeout page %0d got no page_valid exp page", p); end
      checks++; if (pn !== 10'(exp_pn)) begin errors++; $display("FAIL sim_page_num got %0d exp %0d", pn, exp_pn); end
      checks++; if (cs !== ecs) begin errors++; $display("FAIL sim_csum got %h exp %h", cs, ecs); end
      for (int i = 0; i < PB; i++) begin
        checks++; if (got[i] !== exp_pg[i]) begin errors++; $display("FAIL sim_data page %0d idx %0d got %h exp %h", p, i, got[i], exp_pg[i]); end
      end
      release_page(d1, d2);
      exp_pn = (exp_pn + 1) % NP;
    end
    checks++; if (rd_pulses - base != 2 * PB) begin errors++; $display("FAIL sim_total_reads got %0d exp %0d", rd_pulses - base, 2 * PB); end
  endtask

  task automatic test_async_reset();
    bit ok; logic [9:0] pn; logic [7:0] cs, ecs; logic va, d1, d2;
    int base = rd_pulses;
    int c = 0;
    for (int i = 0; i < PB + 100; i++) push(8'($urandom));
    while (rd_pulses - base < PB + 60 && c < 600) begin cycle(1); c++; end
    checks++; if (page_valid !== 1'b1 || fifo_rd_en !== 1'b1) begin
      errors++; $display("FAIL arst_pre got valid %b rd_en %b exp 1 1", page_valid, fifo_rd_en); end
    #2 nrst = 1'b0;
    #1;
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL arst_rd_en got %b exp 0", fifo_rd_en); end
    checks++; if (page_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", page_valid); end
    checks++; if (page_num !== 10'd0) begin errors++; $display("FAIL arst_page_num got %0d exp 0", page_num); end
    cycle(3);
    nrst = 1'b1;
    exp_stream.delete();
    fill_pos = 0;
    exp_pn = 0;
    cycle(2);
    for (int i = 0; i < PB; i++) push(8'($urandom));
    grab_page(400, ok, pn, cs, va);
    ecs = next_page();
    checks++; if (!ok) begin errors++; $display("FAIL arst_timeout got no page_valid exp page"); end
    checks++; if (pn !== 10'd0) begin errors++; $display("FAIL arst_page_num_after got %0d exp 0", pn); end
    checks++; if (cs !== ecs) begin errors++; $display("FAIL arst_csum got %h exp %h", cs, ecs); end
    for (int i = 0; i < PB; i++) begin
      checks++; if (got[i] !== exp_pg[i]) begin errors++; $display("FAIL arst_data idx %0d got %h exp %h", i, got[i], exp_pg[i]); end
    end
    release_page(d1, d2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_pad();
    test_wrap();
    test_simultaneous();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got no finish exp finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/page_assembler.md
Name: page_assembler

Overview:
- Sits between the UART receive FIFO and the EEPROM page writer.
- Drains bytes from the FIFO into two ping-pong 128-byte page buffers.
- Hands each completed page to the writer with a take/release ownership handshake, so UART traffic keeps filling one buffer while the writer programs the other and waits out its program time.
- Pads a partially filled page after an idle timeout so the final page of an image still gets written.

Parameters:
- PAGE_BYTES, 128, bytes per page; power of two; matches the EEPROM page size.
- NUM_PAGES, 1024, pages per image (128 KiB / 128).
- TIMEOUT_CYC, 70000, idle clk cycles before a partial page is padded (10 ms at 7 MHz).
- PAD_BYTE, 8'hFF, fill value for padded bytes.

Ports:
- clk  in  1  7 MHz system clock
- nrst  in  1  asynchronous active-low reset
- fifo_empty  in  1  FIFO empty flag
- fifo_dout  in  8  FIFO read data, valid the cycle after fifo_rd_en
- fifo_rd_en  out  1  FIFO read strobe
- page_valid  out  1  a full page is available to take
- page_take  in  1  writer takes ownership; counts only when page_valid=1
- page_num  out  10  page index of the offered/owned page
- rd_idx  in  7  byte index within the owned page
- rd_data  out  8  buffer byte; 1-cycle registered read latency
- page_release  in  1  writer done with the owned page; frees its buffer
- image_done  out  1  1-cycle pulse when page NUM_PAGES-1 is released
- page_csum  out  8  XOR of all page bytes; see Optional Feature

Behaviour:
- Reset: all outputs 0, both buffers EMPTY, fill pointer = buffer 0, byte count 0, page counter 0, timer 0. Buffer RAM contents are not cleared. Async assert; deassert is taken synchronously into the first clk edge.
- Buffer states: EMPTY -> FILLING -> FULL -> OWNED -> EMPTY.
  - Only one buffer may be OWNED at a time.
  - Buffers are offered in fill order.
- Fill FSM states: IDLE, FILL, PAD.
  - IDLE -> FILL when the fill buffer is EMPTY and fifo_empty=0.
  - FILL:
    - Assert fifo_rd_en when fifo_empty=0 and (count + reads in flight) < PAGE_BYTES.
    - Write fifo_dout to buffer[count] one cycle after each rd_en; count increments per written byte.
    - When count reaches PAGE_BYTES: mark buffer FULL, toggle the fill pointer, clear count, go to IDLE.
  - Timer counts cycles in FILL with no rd_en issued and count > 0. It clears on any rd_en.
  - FILL -> PAD when the timer reaches TIMEOUT_CYC.
  - PAD writes PAD_BYTE at 1 byte/cycle until count = PAGE_BYTES, then takes the same completion path as FILL. fifo_rd_en=0 throughout PAD.
  - If count = 0, no timeout occurs; the block waits indefinitely.
- Backpressure: if the other buffer is not EMPTY when a page completes, the FSM stays in IDLE with fifo_rd_en=0 until that buffer frees. The UART then backs up into the FIFO.
- Offer:
  - page_valid=1 when the oldest FULL buffer exists and no buffer is OWNED.
  - page_valid && page_take => buffer becomes OWNED and page_valid drops the next cycle.
  - page_num holds the index of the offered page, and of the owned page while OWNED.
- Read port: rd_data <= owned_buffer[rd_idx] every cycle. Value is undefined while nothing is OWNED.
- Release:
  - page_release while OWNED => buffer EMPTY and page counter +1.
  - Counter wraps NUM_PAGES-1 -> 0.
  - image_done pulses on the release of page NUM_PAGES-1.
  - page_release with nothing OWNED is ignored.
- Simultaneous events:
  - Release and fill completion in the same cycle: the freed buffer is usable the next cycle.
  - Take and release in the same cycle: release applies to the currently owned buffer. The take is ignored because page_valid was 0.

Optional Feature:
- Macro PAGE_CSUM_EN.
- Defined: a per-buffer 8-bit XOR accumulates every written byte, including pad bytes. page_csum shows the offered/owned buffer's value, valid while page_valid or OWNED.
- Undefined: page_csum is tied 8'h00 and no accumulator logic exists.

Decomposition:
- Package stream_pkg:
  - PAGE_BYTES and NUM_PAGES defaults.
  - fill_state_t {IDLE, FILL, PAD}.
  - buf_state_t {EMPTY, FILLING, FULL, OWNED}.
- Sub-module page_ram: 2x128x8 simple dual-port RAM, one sync write port and one registered read port, inferred as BRAM/LUTRAM. Address = {buffer bit, index}.

Test Plan:
- Push 128 bytes 0x00..0x7F, take, read idx 0..127 -> rd_data 0x00..0x7F one cycle after each idx; page_num=0; page_csum=0x00 with PAGE_CSUM_EN.
- Push 300 bytes with no take -> exactly 256 fifo_rd_en pulses; fifo_rd_en stays 0 until the first release; the remaining 44 bytes are then drained.
- Push 5 bytes 0x11, idle 70000 cycles -> PAD; page_valid rises; idx 0..4 = 0x11, idx 5..127 = 0xFF.
- Take/release 1024 pages -> page_num 0..1023; image_done pulses once on release of page 1023; next offered page_num = 0.
- Assert nrst low mid-FILL at count 60 -> fifo_rd_en and page_valid drop immediately (async); after release, 128 fresh bytes produce page_num=0 data with no stale bytes.
- Release and fill completion in the same cycle with both buffers busy -> no byte lost or duplicated; the next page data matches the pushed sequence.
